// File: rtl/fault_monitor_pkg.sv
// rtl/fault_monitor_pkg.sv - shared state encoding and sizing helpers for fault_monitor
//
// Purpose: supervisor state encoding plus the clog2 helpers used to size
// fault_code and trip_count.
// Ports: none (package).
package fault_monitor_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_FAULT    = 2'b01,
    ST_COOLDOWN = 2'b10,
    ST_LOCKOUT  = 2'b11
  } fm_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Field width that never collapses to zero bits (e.g. a single channel).
  function automatic int width_min1(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fault_debounce.sv
// rtl/fault_debounce.sv - per-channel saturating debounce counter
//
// Purpose: qualifies one fault channel after DEBOUNCE_CYCLES consecutive
// active samples; any inactive sample (or mask) restarts the count.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   in         : raw fault request
//   mask       : 1 = channel ignored (counter held at 0)
//   qual       : channel qualified (counter saturated), combinational
module fault_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEBOUNCE_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic mask,
  output logic qual
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = DEBOUNCE_W'(DEBOUNCE_CYCLES);

  logic [DEBOUNCE_W-1:0] cnt;
  logic                  active;

  assign active = in & ~mask;
  assign qual   = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + DEBOUNCE_W'(1);
    end
  end

endmodule

// File: rtl/fault_monitor.sv
// rtl/fault_monitor.sv - multi-channel fault supervisor with retry cooldown and lockout
//
// Purpose: debounces NUM_FAULTS fault inputs, latches tripped channels,
// reports the first cause, and runs retry/lockout sequencing.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   fault_in      : raw fault requests, one bit per channel
//   fault_mask    : 1 = channel ignored
//   clear         : single-cycle host clear pulse
//   fault         : drive inhibit (FAULT, COOLDOWN, LOCKOUT)
//   fault_latched : sticky record of qualified channels
//   fault_code    : lowest qualified channel index of the last trip
//   state         : 00 OK, 01 FAULT, 10 COOLDOWN, 11 LOCKOUT
//   trip_count    : trips since reset or counter decay
module fault_monitor
  import fault_monitor_pkg::*;
#(
  parameter int NUM_FAULTS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEBOUNCE_W      = 8,
  parameter int RETRY_CYCLES    = 50000,
  parameter int RETRY_W         = 16,
  parameter int MAX_TRIPS       = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_FAULTS-1:0]                  fault_in,
  input  logic [NUM_FAULTS-1:0]                  fault_mask,
  input  logic                                   clear,
  output logic                                   fault,
  output logic [NUM_FAULTS-1:0]                  fault_latched,
  output logic [width_min1(NUM_FAULTS)-1:0]      fault_code,
  output logic [1:0]                             state,
  output logic [width_min1(MAX_TRIPS+1)-1:0]     trip_count
);

  localparam int CODE_W = width_min1(NUM_FAULTS);
  localparam int TRIP_W = width_min1(MAX_TRIPS + 1);
  localparam logic [TRIP_W-1:0]  TRIP_MAX  = TRIP_W'(MAX_TRIPS);
  localparam logic [RETRY_W-1:0] TIMER_END = RETRY_W'(RETRY_CYCLES - 1);

  fm_state_t             state_q;
  logic [RETRY_W-1:0]    timer;
  logic [NUM_FAULTS-1:0] qual;
  logic                  any_qual;
  logic                  any_active;
  logic [CODE_W-1:0]     first_code;
  logic [TRIP_W-1:0]     trip_inc;
  logic                  lockout_exit;

  for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_db
    fault_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DEBOUNCE_W     (DEBOUNCE_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .in   (fault_in[i]),
      .mask (fault_mask[i]),
      .qual (qual[i])
    );
  end

  assign any_qual     = |qual;
  assign any_active   = |(fault_in & ~fault_mask);
  assign trip_inc     = (trip_count == TRIP_MAX) ? TRIP_MAX : trip_count + TRIP_W'(1);
  assign lockout_exit = (state_q == ST_LOCKOUT) && clear && !any_active;
  assign state        = state_q;

  // Lowest index wins: scan downward so the last assignment is the lowest bit.
  always_comb begin
    first_code = '0;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (qual[i]) first_code = CODE_W'(i);
    end
  end

  // Latch register: clear drops old history but keeps channels qualifying now;
  // in LOCKOUT clear only takes effect together with a successful exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_latched <= '0;
    end else if (state_q == ST_LOCKOUT) begin
      fault_latched <= lockout_exit ? '0 : (fault_latched | qual);
    end else begin
      fault_latched <= (clear ? '0 : fault_latched) | qual;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OK;
      fault      <= 1'b0;
      fault_code <= '0;
      trip_count <= '0;
      timer      <= '0;
    end else begin
      case (state_q)
        ST_OK, ST_COOLDOWN: begin
          if (any_qual) begin
            // New trip; qual has priority over cooldown expiry on the same edge.
            state_q    <= (trip_inc == TRIP_MAX) ? ST_LOCKOUT : ST_FAULT;
            fault      <= 1'b1;
            fault_code <= first_code;
            trip_count <= trip_inc;
            timer      <= '0;
          end else if (state_q == ST_COOLDOWN) begin
            if (timer >= TIMER_END) begin
              state_q <= ST_OK;
              fault   <= 1'b0;
              timer   <= '0;
            end else begin
              timer <= timer + RETRY_W'(1);
            end
          end else if (trip_count != '0) begin
            // A clean run of RETRY_CYCLES in OK forgives earlier trips.
            if (timer >= TIMER_END) begin
              trip_count <= '0;
              timer      <= '0;
            end else begin
              timer <= timer + RETRY_W'(1);
            end
          end
        end
        ST_FAULT: begin
          fault <= 1'b1;
          if (!any_active) begin
            state_q <= ST_COOLDOWN;
            timer   <= '0;
          end
        end
        default: begin // ST_LOCKOUT
          if (lockout_exit) begin
            state_q    <= ST_OK;
            fault      <= 1'b0;
            trip_count <= '0;
            timer      <= '0;
          end else begin
            fault <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_monitor.sv
// tb/tb_fault_monitor.sv - directed self-checking bench for fault_monitor
module tb_fault_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] fault_in;
  logic [3:0] fault_mask;
  logic       clear;
  logic       fault;
  logic [3:0] fault_latched;
  logic [1:0] fault_code;
  logic [1:0] state;
  logic [1:0] trip_count;

  int passed = 0;
  int total  = 0;

  fault_monitor #(
    .NUM_FAULTS     (4),
    .DEBOUNCE_CYCLES(4),
    .DEBOUNCE_W     (8),
    .RETRY_CYCLES   (10),
    .RETRY_W        (16),
    .MAX_TRIPS      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fault_in     (fault_in),
    .fault_mask   (fault_mask),
    .clear        (clear),
    .fault        (fault),
    .fault_latched(fault_latched),
    .fault_code   (fault_code),
    .state        (state),
    .trip_count   (trip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fault_in = '0;
    fault_mask = '0;
    clear = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fault_in = 4'b1111;
    fault_mask = '0;
    clear = 1'b0;
    step(3);
    total++; if (fault !== 1'b0) $display("FAIL reset_fault got %0h exp 0", fault); else passed++;
    total++; if (state !== 2'b00) $display("FAIL reset_state got %0h exp 0", state); else passed++;
    total++; if (fault_latched !== 4'b0000) $display("FAIL reset_latched got %0h exp 0", fault_latched); else passed++;
    total++; if (fault_code !== 2'd0) $display("FAIL reset_code got %0h exp 0", fault_code); else passed++;
    total++; if (trip_count !== 2'd0) $display("FAIL reset_trip got %0h exp 0", trip_count); else passed++;
    fault_in = '0;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_debounce();
    do_reset();
    fault_in = 4'b0001; step(3);
    fault_in = 4'b0000; step(2);
    total++; if (fault !== 1'b0) $display("FAIL db_short_fault got %0h exp 0", fault); else passed++;
    fault_in = 4'b0001; step(4);
    total++; if (fault !== 1'b0) $display("FAIL db_edge4_fault got %0h exp 0", fault); else passed++;
    step(1);
    total++; if (fault !== 1'b1) $display("FAIL db_fault got %0h exp 1", fault); else passed++;
    total++; if (state !== 2'b01) $display("FAIL db_state got %0h exp 1", state); else passed++;
    total++; if (fault_code !== 2'd0) $display("FAIL db_code got %0h exp 0", fault_code); else passed++;
    total++; if (trip_count !== 2'd1) $display("FAIL db_trip got %0h exp 1", trip_count); else passed++;
    total++; if (fault_latched !== 4'b0001) $display("FAIL db_latched got %0h exp 1", fault_latched); else passed++;
  endtask

  // Continues from the tripped state left by test_debounce.
  task automatic test_retry();
    fault_in = 4'b0000; step(1);
    total++; if (state !== 2'b10) $display("FAIL retry_cool got %0h exp 2", state); else passed++;
    step(9);
    total++; if (state !== 2'b10) $display("FAIL retry_cool9 got %0h exp 2", state); else passed++;
    step(1);
    total++; if (state !== 2'b00) $display("FAIL retry_ok got %0h exp 0", state); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL retry_fault got %0h exp 0", fault); else passed++;
    total++; if (fault_latched !== 4'b0001) $display("FAIL retry_latched got %0h exp 1", fault_latched); else passed++;
    step(9);
    total++; if (trip_count !== 2'd1) $display("FAIL retry_trip9 got %0h exp 1", trip_count); else passed++;
    step(1);
    total++; if (trip_count !== 2'd0) $display("FAIL retry_decay got %0h exp 0", trip_count); else passed++;
    clear = 1'b1; step(1); clear = 1'b0;
    total++; if (fault_latched !== 4'b0000) $display("FAIL ok_clear_latched got %0h exp 0", fault_latched); else passed++;
    total++; if (state !== 2'b00) $display("FAIL ok_clear_state got %0h exp 0", state); else passed++;
  endtask

  task automatic test_mask();
    do_reset();
    fault_mask = 4'b0010;
    fault_in = 4'b1010; step(5);
    total++; if (state !== 2'b01) $display("FAIL mask_state got %0h exp 1", state); else passed++;
    total++; if (fault_code !== 2'd3) $display("FAIL mask_code got %0h exp 3", fault_code); else passed++;
    total++; if (fault_latched !== 4'b1000) $display("FAIL mask_latched got %0h exp 8", fault_latched); else passed++;
    total++; if (trip_count !== 2'd1) $display("FAIL mask_trip got %0h exp 1", trip_count); else passed++;
    // Clear in FAULT keeps bits that are qualifying on that edge.
    clear = 1'b1; step(1); clear = 1'b0;
    total++; if (fault_latched !== 4'b1000) $display("FAIL fault_clear_latched got %0h exp 8", fault_latched); else passed++;
    total++; if (state !== 2'b01) $display("FAIL fault_clear_state got %0h exp 1", state); else passed++;
    fault_in = '0; fault_mask = '0;
  endtask

  task automatic test_lockout();
    do_reset();
    fault_in = 4'b0001; step(5);
    fault_in = 4'b0000; step(1);
    fault_in = 4'b0001; step(5);
    total++; if (state !== 2'b11) $display("FAIL lock_state got %0h exp 3", state); else passed++;
    total++; if (trip_count !== 2'd2) $display("FAIL lock_trip got %0h exp 2", trip_count); else passed++;
    clear = 1'b1; step(1); clear = 1'b0;
    total++; if (state !== 2'b11) $display("FAIL lock_clear_active got %0h exp 3", state); else passed++;
    total++; if (fault_latched !== 4'b0001) $display("FAIL lock_latched got %0h exp 1", fault_latched); else passed++;
    step(12);
    total++; if (state !== 2'b11) $display("FAIL lock_hold got %0h exp 3", state); else passed++;
    fault_in = 4'b0000; clear = 1'b1; step(1); clear = 1'b0;
    total++; if (state !== 2'b00) $display("FAIL lock_exit_state got %0h exp 0", state); else passed++;
    total++; if (trip_count !== 2'd0) $display("FAIL lock_exit_trip got %0h exp 0", trip_count); else passed++;
    total++; if (fault_latched !== 4'b0000) $display("FAIL lock_exit_latched got %0h exp 0", fault_latched); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL lock_exit_fault got %0h exp 0", fault); else passed++;
  endtask

  // Channel 1 qualifies just before the cooldown expiry edge (timer = 9).
  task automatic test_retrip();
    do_reset();
    fault_in = 4'b0001; step(5);
    fault_in = 4'b0000; step(1);
    step(5);
    fault_in = 4'b0010; step(4);
    total++; if (state !== 2'b10) $display("FAIL retrip_pre got %0h exp 2", state); else passed++;
    step(1);
    total++; if (state !== 2'b11) $display("FAIL retrip_state got %0h exp 3", state); else passed++;
    total++; if (fault_code !== 2'd1) $display("FAIL retrip_code got %0h exp 1", fault_code); else passed++;
    total++; if (trip_count !== 2'd2) $display("FAIL retrip_trip got %0h exp 2", trip_count); else passed++;
    total++; if (fault_latched !== 4'b0011) $display("FAIL retrip_latched got %0h exp 3", fault_latched); else passed++;
    fault_in = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    fault_in = 4'b0001; step(5);
    fault_in = 4'b0000; step(4);
    total++; if (state !== 2'b10) $display("FAIL areset_pre got %0h exp 2", state); else passed++;
    reset = 1'b1;
    #1;
    total++; if (state !== 2'b00) $display("FAIL areset_state got %0h exp 0", state); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL areset_fault got %0h exp 0", fault); else passed++;
    total++; if (fault_latched !== 4'b0000) $display("FAIL areset_latched got %0h exp 0", fault_latched); else passed++;
    total++; if (trip_count !== 2'd0) $display("FAIL areset_trip got %0h exp 0", trip_count); else passed++;
    #1;
    reset = 1'b0;
    step(1);
    fault_in = 4'b0001; step(4);
    total++; if (fault !== 1'b0) $display("FAIL areset_edge4 got %0h exp 0", fault); else passed++;
    step(1);
    total++; if (fault !== 1'b1) $display("FAIL areset_retrip got %0h exp 1", fault); else passed++;
    fault_in = '0;
  endtask

  initial begin
    reset = 1'b1;
    fault_in = '0;
    fault_mask = '0;
    clear = 1'b0;
    test_reset();
    test_debounce();
    test_retry();
    test_mask();
    test_lockout();
    test_retrip();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fault_monitor.md
Name: fault_monitor

Overview:
- Parametrised multi-channel fault supervisor for the BLDC drive.
- Debounces N independent fault inputs (overcurrent, no feedback, over-temperature, undervoltage, ...), latches which channels tripped, and reports the first cause.
- Runs a timed auto-retry cooldown with a trip counter that escalates to a lockout, which only a host clear can release.
- Sits between the sensing logic and the commutation/PWM block; `fault` gates the PWM drive.

Parameters:
- NUM_FAULTS, 4, number of fault input channels (1..16).
- DEBOUNCE_CYCLES, 16, consecutive high samples needed to qualify a channel (>=1).
- DEBOUNCE_W, 8, debounce counter width; must hold DEBOUNCE_CYCLES.
- RETRY_CYCLES, 50000, cooldown length; also the clean-run time that resets the trip counter (>=1).
- RETRY_W, 16, timer width; must hold RETRY_CYCLES.
- MAX_TRIPS, 3, trip count that forces LOCKOUT (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fault_in  in  NUM_FAULTS  raw fault requests, bit i = channel i, active high
- fault_mask  in  NUM_FAULTS  1 = channel ignored
- clear  in  1  single-cycle host clear pulse
- fault  out  1  drive-inhibit, high in FAULT, COOLDOWN and LOCKOUT
- fault_latched  out  NUM_FAULTS  sticky record of qualified channels
- fault_code  out  clog2(NUM_FAULTS) (min 1)  index of the channel that caused the last trip
- state  out  2  00 OK, 01 FAULT, 10 COOLDOWN, 11 LOCKOUT
- trip_count  out  clog2(MAX_TRIPS+1) (min 1)  trips since the last reset or counter decay

Behaviour:
- Reset (async) values: state = OK, fault = 0, fault_latched = 0, fault_code = 0, trip_count = 0. All debounce counters and the timer are 0.
- Active channel: fault_in[i] & ~fault_mask[i].
- Debounce, per channel:
  - Active: counter increments and saturates at DEBOUNCE_CYCLES.
  - Inactive: counter resets to 0 the same edge.
  - qual[i] = (counter == DEBOUNCE_CYCLES), combinational.
  - Masking a channel mid-count clears its counter.
- Latency: input sampled high on edges 1..D gives qual after edge D; fault is registered high after edge D+1. A one-cycle dropout restarts the count.
- OK:
  - Timer counts while trip_count > 0. On reaching RETRY_CYCLES, trip_count goes to 0 and the timer to 0.
  - If any qual:
    - go to FAULT and set fault = 1;
    - fault_latched |= qual;
    - fault_code = lowest-index qual bit;
    - trip_count increments, saturating at MAX_TRIPS;
    - timer goes to 0.
  - If the incremented trip_count == MAX_TRIPS, go to LOCKOUT instead of FAULT, with the same latch and code updates.
- FAULT:
  - Hold fault = 1.
  - When no channel is active (raw, not debounced), go to COOLDOWN and load timer = 0.
  - New qual bits OR into fault_latched; fault_code is not changed.
- COOLDOWN:
  - Timer increments each cycle.
  - Any qual returns to FAULT (or LOCKOUT per the rule in OK), counted as a new trip with fault_code updated.
  - When the timer reaches RETRY_CYCLES with no qual, go to OK with fault = 0 and timer = 0.
  - qual and expiry on the same edge: qual wins.
- LOCKOUT:
  - Hold fault = 1 and ignore new trips apart from OR-ing fault_latched.
  - Exit only on clear with no active channel: go to OK, trip_count = 0, timer = 0.
  - clear while any channel is active is ignored.
- clear in OK, FAULT or COOLDOWN:
  - fault_latched goes to 0, except bits whose qual is high that same edge, which stay set.
  - Does not change state or trip_count.
- clear in LOCKOUT with a successful exit also clears fault_latched.
- fault_code keeps its value until the next trip; clear does not alter it.
- Width rules:
  - Counters never wrap: debounce counters, timer and trip_count all saturate.
  - fault_code is sized for NUM_FAULTS = 1 as 1 bit, driven as 0.

Decomposition:
- Package fault_monitor_pkg holds the state encoding constants (ST_OK, ST_FAULT, ST_COOLDOWN, ST_LOCKOUT) and a clog2 helper function.
- Sub-module fault_debounce: one instance per channel via generate.
  - Ports: clk, reset, in, mask, qual.
  - Parameters: DEBOUNCE_CYCLES, DEBOUNCE_W.
- Top level holds the FSM, timer, trip counter, priority encoder and latch register.

Test Plan (NUM_FAULTS=4, DEBOUNCE_CYCLES=4, RETRY_CYCLES=10, MAX_TRIPS=2):
- Debounce: fault_in=0001 for 3 cycles then 0 -> fault stays 0. Held for 5 cycles -> fault=1 after edge 5, state=01, fault_code=0, trip_count=1, fault_latched=0001.
- Simultaneous/mask: fault_in=1010 with fault_mask=0010 held 5 cycles -> fault_code=3, fault_latched=1000. Channel 1 never latches.
- Retry: after a trip, drop fault_in -> state=10 next edge. After 10 cycles -> state=00, fault=0, fault_latched still 0001. 10 further clean cycles -> trip_count=0.
- Lockout: two trips within the cooldown window -> state=11, trip_count=2. clear while fault_in=0001 -> stays 11. clear with fault_in=0 -> state=00, trip_count=0, fault_latched=0.
- Re-trip in cooldown: fault_in asserted 4 cycles at cooldown timer=9 -> qual on the expiry edge wins, state=01 (or 11 if at MAX_TRIPS).
- Async reset: assert reset mid-COOLDOWN with no clk edge -> all outputs 0 immediately. After release, fault_in needs a full 4+1 cycles to trip.
